// File: rtl/approx_units_array_pipe_pkg.sv
// approx_units_array_pipe_pkg: default geometry and derived shift-amount width helper for the DRUM pre-approximation pipe
package approx_units_array_pipe_pkg;
  localparam int MULT_DW_DEF = 4;
  localparam int A_BW_DEF = 8;
  localparam int B_BW_DEF = 8;
  localparam int M_DEF = 3;
  localparam int N_DEF = 3;
  localparam int SKEW_EN_DEF = 1;
  function automatic int shamt_w(input int bw);
    return $clog2(bw);
  endfunction
endpackage

// File: rtl/approx_units_array_pipe_if.sv
// approx_units_array_pipe_if: input vectors + valid/ready handshake and approximated per-row/column outputs; slave=pipe, master=driver
interface approx_units_array_pipe_if
  import approx_units_array_pipe_pkg::*;
#(
  parameter int MULT_DW = MULT_DW_DEF,
  parameter int A_BW = A_BW_DEF,
  parameter int B_BW = B_BW_DEF,
  parameter int M = M_DEF,
  parameter int N = N_DEF,
  parameter int AS_W = shamt_w(A_BW),
  parameter int BS_W = shamt_w(B_BW)
);
  logic in_valid;
  logic in_ready;
  logic unbias_en;
  logic out_ready;
  logic [A_BW*M-1:0] data;
  logic [B_BW*N-1:0] kernel;
  logic [MULT_DW*M-1:0] syst_data;
  logic [MULT_DW*N-1:0] syst_kernel;
  logic [M-1:0] d_sign;
  logic [N-1:0] w_sign;
  logic [AS_W*M-1:0] d_shamt;
  logic [BS_W*N-1:0] w_shamt;
  logic [M-1:0] d_zero;
  logic [N-1:0] w_zero;
  logic [M-1:0] d_valid;
  logic [N-1:0] w_valid;
  modport slave (
    input in_valid, unbias_en, data, kernel, out_ready,
    output in_ready, syst_data, syst_kernel, d_sign, w_sign, d_shamt, w_shamt, d_zero, w_zero, d_valid, w_valid
  );
  modport master (
    output in_valid, unbias_en, data, kernel, out_ready,
    input in_ready, syst_data, syst_kernel, d_sign, w_sign, d_shamt, w_shamt, d_zero, w_zero, d_valid, w_valid
  );
endinterface

// File: rtl/approx_units_array_pipe_drum_pre_approx_stage.sv
// drum_pre_approx_stage: one channel of combinational sign/abs/leading-one/window/unbias; operand,unbias_en -> mult,sign,shamt,zero
module drum_pre_approx_stage #(
  parameter int BW = 8,
  parameter int MULT_DW = 4,
  parameter int SW = $clog2(BW)
) (
  input  logic [BW-1:0]      operand,
  input  logic               unbias_en,
  output logic [MULT_DW-1:0] mult,
  output logic               sign,
  output logic [SW-1:0]      shamt,
  output logic               zero
);
  logic [BW-1:0] mag;
  logic [SW-1:0] k;
  logic big;
  assign mag = operand[BW-1] ? -operand : operand;
  always_comb begin
    k = '0;
    for (int i = 1; i < BW; i++) k = mag[i] ? SW'(i) : k;
  end
  assign zero = ~|mag;
  assign sign = operand[BW-1];
  assign big = {1'b0, k} >= (SW+1)'(MULT_DW);
  assign shamt = big ? k - SW'(MULT_DW - 1) : '0;
  assign mult = MULT_DW'(mag >> shamt) | {{(MULT_DW-1){1'b0}}, big & unbias_en};
endmodule

// File: rtl/approx_units_array_pipe.sv
// approx_units_array_pipe: registered DRUM pre-approx front end with stall-on-out_ready handshake and optional diagonal skew; clk,rst_n + bus(slave)
module approx_units_array_pipe
  import approx_units_array_pipe_pkg::*;
#(
  parameter int MULT_DW = MULT_DW_DEF,
  parameter int A_BW = A_BW_DEF,
  parameter int B_BW = B_BW_DEF,
  parameter int M = M_DEF,
  parameter int N = N_DEF,
  parameter int SKEW_EN = SKEW_EN_DEF,
  parameter int AS_W = shamt_w(A_BW),
  parameter int BS_W = shamt_w(B_BW)
) (
  input logic clk,
  input logic rst_n,
  approx_units_array_pipe_if.slave bus
);
  localparam int DW = 3 + AS_W + MULT_DW;
  localparam int KW = 3 + BS_W + MULT_DW;
  logic adv;
  logic s1_valid;
  logic s1_unb;
  logic [A_BW*M-1:0] s1_data;
  logic [B_BW*N-1:0] s1_kernel;
  logic [DW-1:0] d_tap [M];
  logic [KW-1:0] w_tap [N];
  assign adv = bus.out_ready;
  assign bus.in_ready = bus.out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_unb <= 1'b0;
      s1_data <= '0;
      s1_kernel <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_unb <= bus.in_valid & bus.unbias_en;
      s1_data <= bus.in_valid ? bus.data : '0;
      s1_kernel <= bus.in_valid ? bus.kernel : '0;
    end
  end
  for (genvar m = 0; m < M; m++) begin : g_row
    localparam int D = (SKEW_EN != 0) ? m : 0;
    logic [MULT_DW-1:0] mult;
    logic [AS_W-1:0] shamt;
    logic sign;
    logic zero;
    logic [DW-1:0] sr [D+1];
    drum_pre_approx_stage #(.BW(A_BW), .MULT_DW(MULT_DW), .SW(AS_W)) u_drum (
      .operand(s1_data[A_BW*m +: A_BW]),
      .unbias_en(s1_unb),
      .mult(mult),
      .sign(sign),
      .shamt(shamt),
      .zero(zero)
    );
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= D; j++) sr[j] <= '0;
      end else if (adv) begin
        sr[0] <= s1_valid ? {1'b1, sign, zero, shamt, mult} : '0;
        for (int j = 1; j <= D; j++) sr[j] <= sr[j-1];
      end
    end
    assign d_tap[m] = sr[D];
  end
  for (genvar n = 0; n < N; n++) begin : g_col
    localparam int D = (SKEW_EN != 0) ? n : 0;
    logic [MULT_DW-1:0] mult;
    logic [BS_W-1:0] shamt;
    logic sign;
    logic zero;
    logic [KW-1:0] sr [D+1];
    drum_pre_approx_stage #(.BW(B_BW), .MULT_DW(MULT_DW), .SW(BS_W)) u_drum (
      .operand(s1_kernel[B_BW*n +: B_BW]),
      .unbias_en(s1_unb),
      .mult(mult),
      .sign(sign),
      .shamt(shamt),
      .zero(zero)
    );
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= D; j++) sr[j] <= '0;
      end else if (adv) begin
        sr[0] <= s1_valid ? {1'b1, sign, zero, shamt, mult} : '0;
        for (int j = 1; j <= D; j++) sr[j] <= sr[j-1];
      end
    end
    assign w_tap[n] = sr[D];
  end
  always_comb begin
    bus.d_valid = '0;
    bus.d_sign = '0;
    bus.d_zero = '0;
    bus.d_shamt = '0;
    bus.syst_data = '0;
    bus.w_valid = '0;
    bus.w_sign = '0;
    bus.w_zero = '0;
    bus.w_shamt = '0;
    bus.syst_kernel = '0;
    for (int i = 0; i < M; i++)
      {bus.d_valid[i], bus.d_sign[i], bus.d_zero[i], bus.d_shamt[AS_W*i +: AS_W], bus.syst_data[MULT_DW*i +: MULT_DW]} = d_tap[i];
    for (int i = 0; i < N; i++)
      {bus.w_valid[i], bus.w_sign[i], bus.w_zero[i], bus.w_shamt[BS_W*i +: BS_W], bus.syst_kernel[MULT_DW*i +: MULT_DW]} = w_tap[i];
  end
endmodule

// File: tb/tb_approx_units_array_pipe.sv
// tb_approx_units_array_pipe: randomized + directed scoreboard bench for approx_units_array_pipe
module tb_approx_units_array_pipe;
  localparam int MW = 4;
  localparam int BW = 8;
  localparam int M = 3;
  localparam int N = 3;
  localparam int C = M + N;
  localparam int SW = 3;
  typedef struct {
    int when;
    logic [MW-1:0] mult;
    logic sign;
    logic zero;
    logic [SW-1:0] shamt;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int adv_cnt = 0;
  ent_t q [C][$];
  always #5 clk = ~clk;
  approx_units_array_pipe_if #(.MULT_DW(MW), .A_BW(BW), .B_BW(BW), .M(M), .N(N)) bus ();
  approx_units_array_pipe #(.MULT_DW(MW), .A_BW(BW), .B_BW(BW), .M(M), .N(N), .SKEW_EN(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  task automatic chk(input string nm, input int ch, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %0h expected %0h", nm, ch, act, exp);
    end
  endtask
  function automatic ent_t model(input logic [7:0] op, input logic unb, input int when);
    int v;
    int mag;
    int k;
    int sh;
    ent_t e;
    v = int'($signed(op));
    mag = v < 0 ? -v : v;
    k = 0;
    while ((mag >> (k + 1)) != 0) k++;
    e.when = when;
    e.sign = v < 0;
    e.zero = mag == 0;
    if (mag == 0 || k < MW) begin
      e.mult = MW'(mag);
      e.shamt = '0;
    end else begin
      sh = k - MW + 1;
      e.shamt = SW'(sh);
      e.mult = MW'(mag >> sh) | MW'(unb);
    end
    return e;
  endfunction
  function automatic ent_t act(input int c);
    ent_t e;
    int n;
    n = c - M;
    e.when = 0;
    if (c < M) begin
      e.mult = bus.syst_data[MW*c +: MW];
      e.sign = bus.d_sign[c];
      e.zero = bus.d_zero[c];
      e.shamt = bus.d_shamt[SW*c +: SW];
    end else begin
      e.mult = bus.syst_kernel[MW*n +: MW];
      e.sign = bus.w_sign[n];
      e.zero = bus.w_zero[n];
      e.shamt = bus.w_shamt[SW*n +: SW];
    end
    return e;
  endfunction
  function automatic logic vld(input int c);
    return c < M ? bus.d_valid[c] : bus.w_valid[c-M];
  endfunction
  function automatic logic [63:0] outs();
    return {4'b0, bus.syst_data, bus.syst_kernel, bus.d_sign, bus.w_sign, bus.d_shamt, bus.w_shamt,
            bus.d_zero, bus.w_zero, bus.d_valid, bus.w_valid};
  endfunction
  function automatic logic [7:0] rnd8();
    int r;
    r = $urandom_range(0, 7);
    return r == 0 ? 8'h00 : r == 1 ? 8'h80 : 8'($urandom);
  endfunction
  always @(posedge clk) begin
    if (rst_n && bus.out_ready) begin
      if (bus.in_valid)
        for (int c = 0; c < C; c++)
          q[c].push_back(model(c < M ? bus.data[BW*c +: BW] : bus.kernel[BW*(c-M) +: BW], bus.unbias_en,
                               adv_cnt + 2 + (c < M ? c : c - M)));
      adv_cnt++;
    end
  end
  always @(negedge clk) begin
    chk("in_ready", 0, bus.in_ready, bus.out_ready);
    if (rst_n && bus.out_ready) begin
      for (int c = 0; c < C; c++) begin
        ent_t a;
        ent_t e;
        logic due;
        a = act(c);
        due = q[c].size() > 0 && q[c][0].when == adv_cnt;
        chk("valid", c, vld(c), due);
        if (vld(c) && due) begin
          e = q[c].pop_front();
          chk("mult", c, a.mult, e.mult);
          chk("sign", c, a.sign, e.sign);
          chk("zero", c, a.zero, e.zero);
          chk("shamt", c, a.shamt, e.shamt);
        end else if (!vld(c)) begin
          chk("bubble_zero", c, {a.mult, a.sign, a.zero, a.shamt}, '0);
        end
      end
    end
  end
  task automatic drive(input logic [23:0] d, input logic [23:0] k, input logic u, input logic v);
    bus.data = d;
    bus.kernel = k;
    bus.unbias_en = u;
    bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    drive(24'h0, 24'h0, 1'b0, 1'b0);
  endtask
  task automatic drive_rnd();
    drive({rnd8(), rnd8(), rnd8()}, {rnd8(), rnd8(), rnd8()}, 1'($urandom), 1'b1);
  endtask
  logic [63:0] snap;
  initial begin
    bus.in_valid = 1'b0;
    bus.unbias_en = 1'b0;
    bus.data = '0;
    bus.kernel = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_outs", 0, outs(), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive({8'd0, 8'd0, 8'd100}, 24'h0, 1'b1, 1'b1);
    idle();
    chk("d100_unb_mult", 0, bus.syst_data[3:0], 4'b1101);
    chk("d100_unb_shamt", 0, bus.d_shamt[2:0], 3'd3);
    chk("d100_unb_sign", 0, bus.d_sign[0], 1'b0);
    chk("d100_unb_valid", 0, bus.d_valid[0], 1'b1);
    drive({8'd0, 8'd0, 8'd100}, 24'h0, 1'b0, 1'b1);
    idle();
    chk("d100_plain_mult", 0, bus.syst_data[3:0], 4'b1100);
    drive({8'd5, 8'h80, 8'h9C}, {8'd7, 8'd0, 8'hFF}, 1'b1, 1'b1);
    idle();
    chk("m100_mult", 0, bus.syst_data[3:0], 4'b1101);
    chk("m100_shamt", 0, bus.d_shamt[2:0], 3'd3);
    chk("m100_sign", 0, bus.d_sign[0], 1'b1);
    idle();
    chk("m128_mult", 1, bus.syst_data[7:4], 4'b1001);
    chk("m128_shamt", 1, bus.d_shamt[5:3], 3'd4);
    chk("m128_sign", 1, bus.d_sign[1], 1'b1);
    chk("kzero_flag", 1, bus.w_zero[1], 1'b1);
    chk("kzero_mult", 1, bus.syst_kernel[7:4], 4'b0000);
    chk("kzero_shamt", 1, bus.w_shamt[5:3], 3'd0);
    chk("kzero_sign", 1, bus.w_sign[1], 1'b0);
    idle();
    chk("d5_mult", 2, bus.syst_data[11:8], 4'b0101);
    chk("d5_shamt", 2, bus.d_shamt[8:6], 3'd0);
    chk("d5_sign", 2, bus.d_sign[2], 1'b0);
    repeat (3) drive_rnd();
    repeat (6) idle();
    drive_rnd();
    drive_rnd();
    bus.out_ready = 1'b0;
    bus.data = {rnd8(), rnd8(), rnd8()};
    bus.in_valid = 1'b1;
    #1;
    snap = outs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_frozen", i, outs(), snap);
      chk("stall_in_ready", i, bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    drive(bus.data, bus.kernel, bus.unbias_en, 1'b1);
    drive_rnd();
    repeat (6) idle();
    drive_rnd();
    drive_rnd();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    for (int c = 0; c < C; c++) q[c].delete();
    #1;
    chk("reset_mid_outs", 0, outs(), '0);
    chk("reset_in_ready", 0, bus.in_ready, bus.out_ready);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_rnd();
    repeat (6) idle();
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = $urandom_range(0, 4) != 0;
      if ($urandom_range(0, 3) != 0) drive_rnd();
      else idle();
    end
    bus.out_ready = 1'b1;
    repeat (10) idle();
    for (int c = 0; c < C; c++) chk("drain_empty", c, q[c].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
